// File: rtl/gcore_pkg.sv
// Shared definitions for the gcore execution controller: opcodes, FSM
// encoding, instruction field positions and field extraction helpers.
package gcore_pkg;

   localparam int XLEN    = 8;
   localparam int NREGS   = 8;
   localparam int REG_AW  = 3;
   localparam int INSTR_W = 16;

   // Instruction field positions (LSB of each 3-bit field).
   localparam int OP_LSB   = 13;
   localparam int RSVD_BIT = 12;
   localparam int RD_LSB   = 9;
   localparam int RS_LSB   = 6;
   localparam int RT_LSB   = 3;
   localparam int OFF_LSB  = 0;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_ILL = 3'b101,
      OP_SLT = 3'b110,
      OP_BZ  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_FETCH  = 2'b00,
      S_DECODE = 2'b01,
      S_EXEC   = 2'b10,
      S_WB     = 2'b11
   } state_e;

   function automatic op_e f_op(input logic [INSTR_W-1:0] i);
      return op_e'(i[OP_LSB +: 3]);
   endfunction

   function automatic logic [REG_AW-1:0] f_rd(input logic [INSTR_W-1:0] i);
      return i[RD_LSB +: REG_AW];
   endfunction

   function automatic logic [REG_AW-1:0] f_rs(input logic [INSTR_W-1:0] i);
      return i[RS_LSB +: REG_AW];
   endfunction

   function automatic logic [REG_AW-1:0] f_rt(input logic [INSTR_W-1:0] i);
      return i[RT_LSB +: REG_AW];
   endfunction

   // BZ offset is split across the rd slot (high bits) and the low 3 bits.
   function automatic logic [XLEN-1:0] bz_offset(input logic [INSTR_W-1:0] i);
      logic [5:0] off;
      off = {i[RD_LSB +: 3], i[OFF_LSB +: 3]};
      return {{(XLEN-6){off[5]}}, off};
   endfunction

endpackage

// File: rtl/regfile.sv
// 8 x 8 register file: two combinational read ports, one synchronous write
// port, r0 hard-wired to zero.
module regfile
   import gcore_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ra1,
   output logic [XLEN-1:0]   rd1,
   input  logic [REG_AW-1:0] ra2,
   output logic [XLEN-1:0]   rd2,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [XLEN-1:0]   wd
);

   logic [XLEN-1:0] mem [NREGS];

   // NOTE: this array is reset deliberately (architectural state must read
   // zero after reset), so it maps to flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '{default: '0};
      end else if (we && wa != '0) begin
         mem[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
   assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/exec_ctrl.sv
// Non-pipelined FETCH/DECODE/EXEC/WB controller. Drives an external ALU
// through ports and owns the pc, instruction register and register file.
module exec_ctrl
   import gcore_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   output logic               imem_req,
   output logic [XLEN-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [2:0]         alu_op,
   output logic [XLEN-1:0]    alu_a,
   output logic [XLEN-1:0]    alu_b,
   input  logic [XLEN-1:0]    alu_ans,
   input  logic               alu_zero,
   output logic [XLEN-1:0]    pc,
   output logic               wb_en,
   output logic [REG_AW-1:0]  wb_addr,
   output logic [XLEN-1:0]    wb_data,
   output logic               illegal
);

   state_e               state;
   state_e               state_nxt;
   logic [INSTR_W-1:0]   ir;
   logic [XLEN-1:0]      ans_q;
   logic                 zero_q;
   logic [XLEN-1:0]      rs_val;
   logic [XLEN-1:0]      rt_val;
   op_e                  op;
   logic [REG_AW-1:0]    rd;
   logic                 fetch_hs;
   logic                 unused_rsvd;

   assign op          = f_op(ir);
   assign rd          = f_rd(ir);
   assign fetch_hs    = imem_req & imem_ack;
   assign imem_addr   = pc;
   assign unused_rsvd = ir[RSVD_BIT];

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nxt;
   end

   // NOTE: defaults first so no path leaves a comb output unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  if (fetch_hs) state_nxt = S_DECODE;
         S_DECODE: state_nxt = (op == OP_ILL) ? S_FETCH : S_EXEC;
         S_EXEC:   state_nxt = S_WB;
         S_WB:     state_nxt = S_FETCH;
         default:  state_nxt = S_FETCH;
      endcase
   end

   // Reset masks the strobes so a WB cycle cut short by rst never writes.
   always_comb begin
      imem_req = 1'b0;
      wb_en    = 1'b0;
      wb_addr  = '0;
      wb_data  = '0;
      case (state)
         S_FETCH: imem_req = run & ~rst;
         S_WB: begin
            if (!rst && op != OP_BZ && rd != '0) begin
               wb_en   = 1'b1;
               wb_addr = rd;
               wb_data = ans_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= '0;
         ir      <= '0;
         alu_op  <= OP_ADD;
         alu_a   <= '0;
         alu_b   <= '0;
         ans_q   <= '0;
         zero_q  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         case (state)
            S_FETCH: if (fetch_hs) ir <= imem_rdata;
            S_DECODE: begin
               alu_op <= op;
               alu_a  <= rs_val;
               alu_b  <= rt_val;
               if (op == OP_ILL) begin
                  illegal <= 1'b1;
                  pc      <= pc + 8'd1;
               end
            end
            S_EXEC: begin
               ans_q  <= alu_ans;
               zero_q <= alu_zero;
            end
            S_WB: pc <= (op == OP_BZ && zero_q) ? pc + 8'd1 + bz_offset(ir)
                                                : pc + 8'd1;
            default: ;
         endcase
      end
   end

   regfile u_regfile (
      .clk (clk),
      .rst (rst),
      .ra1 (f_rs(ir)),
      .rd1 (rs_val),
      .ra2 (f_rt(ir)),
      .rd2 (rt_val),
      .we  (wb_en),
      .wa  (wb_addr),
      .wd  (wb_data)
   );

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed self-checking bench for exec_ctrl with a behavioural ALU and a
// combinational instruction memory indexed by imem_addr.
module tb_exec_ctrl;
   import gcore_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [2:0]  alu_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [7:0]  alu_ans;
   logic        alu_zero;
   logic [7:0]  pc;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [7:0]  wb_data;
   logic        illegal;

   logic [15:0] mem [256];
   logic        ovr_en;
   logic [7:0]  ovr_val;
   logic [7:0]  pc_m;
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   exec_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ans    (alu_ans),
      .alu_zero   (alu_zero),
      .pc         (pc),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .illegal    (illegal)
   );

   assign imem_rdata = mem[imem_addr];

   // There are no immediates, so nonzero seed values are injected through
   // the ALU result while ovr_en is set.
   always_comb begin
      alu_ans = 8'h00;
      case (alu_op)
         OP_ADD:  alu_ans = alu_a + alu_b;
         OP_SUB:  alu_ans = alu_a - alu_b;
         OP_AND:  alu_ans = alu_a & alu_b;
         OP_OR:   alu_ans = alu_a | alu_b;
         OP_XOR:  alu_ans = alu_a ^ alu_b;
         OP_SLT:  alu_ans = ($signed(alu_a) < $signed(alu_b)) ? 8'h01 : 8'h00;
         OP_BZ:   alu_ans = alu_a - alu_b;
         default: alu_ans = 8'h00;
      endcase
      if (ovr_en) alu_ans = ovr_val;
      alu_zero = (alu_ans == 8'h00);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt);
      return {op, 1'b0, rd, rs, rt, 3'b000};
   endfunction

   function automatic logic [15:0] enc_bz(input logic [2:0] rs, input logic [2:0] rt,
                                          input logic [5:0] off);
      return {OP_BZ, 1'b0, off[5:3], rs, rt, off[2:0]};
   endfunction

   // Starts in the first FETCH cycle of an instruction at pc_m and runs until
   // the next FETCH, counting cycles and write-back pulses.
   task automatic run_instr(input string tag, input logic [15:0] instr, input int ack_delay,
                            input int ovr, input logic exp_wb, input logic [2:0] exp_addr,
                            input logic [7:0] exp_data, input logic [7:0] exp_pc,
                            input int exp_cyc);
      int         ncyc;
      int         n_wb;
      int         wb_cyc;
      logic [2:0] got_addr;
      logic [7:0] got_data;
      logic       addr_ok;
      mem[pc_m] = instr;
      ovr_en    = (ovr >= 0);
      ovr_val   = 8'(ovr);
      ncyc      = 0;
      n_wb      = 0;
      wb_cyc    = 0;
      got_addr  = '0;
      got_data  = '0;
      addr_ok   = 1'b1;
      while (ncyc < 40) begin
         imem_ack = (ncyc >= ack_delay);
         #1;
         if (ncyc <= ack_delay && (imem_req !== 1'b1 || imem_addr !== pc_m)) addr_ok = 1'b0;
         if (wb_en === 1'b1) begin
            n_wb++;
            wb_cyc   = ncyc + 1;
            got_addr = wb_addr;
            got_data = wb_data;
         end
         @(posedge clk);
         #1;
         ncyc++;
         if (ncyc >= ack_delay + 2 && imem_req === 1'b1) break;
      end
      ovr_en = 1'b0;
      check({tag, ".cycles"}, ncyc, exp_cyc);
      check({tag, ".req_addr_stable"}, addr_ok, 1);
      check({tag, ".wb_pulses"}, n_wb, exp_wb ? 1 : 0);
      if (exp_wb) begin
         check({tag, ".wb_addr"}, got_addr, exp_addr);
         check({tag, ".wb_data"}, got_data, exp_data);
         check({tag, ".wb_cycle"}, wb_cyc, ack_delay + 4);
      end
      check({tag, ".pc"}, pc, exp_pc);
      pc_m = exp_pc;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      rst      = 1'b1;
      run      = 1'b1;
      imem_ack = 1'b1;
      ovr_en   = 1'b0;
      ovr_val  = 8'h00;
      pc_m     = 8'h00;

      repeat (2) @(posedge clk);
      #1;
      check("rst.imem_req", imem_req, 0);
      check("rst.pc", pc, 8'h00);
      check("rst.wb_en", wb_en, 0);
      check("rst.wb_addr", wb_addr, 0);
      check("rst.wb_data", wb_data, 0);
      check("rst.alu_op", alu_op, 0);
      check("rst.alu_a", alu_a, 0);
      check("rst.alu_b", alu_b, 0);
      check("rst.illegal", illegal, 0);
      rst = 1'b0;
      #1;
      check("post_rst.imem_req", imem_req, 1);

      run_instr("add_r1", enc(OP_ADD, 3'd1, 3'd0, 3'd0), 0, -1, 1'b1, 3'd1, 8'h00, 8'h01, 4);
      run_instr("seed_r2", enc(OP_ADD, 3'd2, 3'd0, 3'd0), 0, 5, 1'b1, 3'd2, 8'h05, 8'h02, 4);
      run_instr("seed_r3", enc(OP_ADD, 3'd3, 3'd0, 3'd0), 0, 3, 1'b1, 3'd3, 8'h03, 8'h03, 4);
      run_instr("sub", enc(OP_SUB, 3'd4, 3'd2, 3'd3), 0, -1, 1'b1, 3'd4, 8'h02, 8'h04, 4);
      run_instr("slt_lt", enc(OP_SLT, 3'd5, 3'd3, 3'd2), 0, -1, 1'b1, 3'd5, 8'h01, 8'h05, 4);
      run_instr("slt_ge", enc(OP_SLT, 3'd5, 3'd2, 3'd3), 0, -1, 1'b1, 3'd5, 8'h00, 8'h06, 4);
      run_instr("xor", enc(OP_XOR, 3'd6, 3'd2, 3'd3), 0, -1, 1'b1, 3'd6, 8'h06, 8'h07, 4);
      run_instr("and", enc(OP_AND, 3'd7, 3'd2, 3'd3), 0, -1, 1'b1, 3'd7, 8'h01, 8'h08, 4);
      run_instr("wr_r0", enc(OP_ADD, 3'd0, 3'd2, 3'd3), 0, -1, 1'b0, 3'd0, 8'h00, 8'h09, 4);
      run_instr("or_r0", enc(OP_OR, 3'd1, 3'd0, 3'd2), 0, -1, 1'b1, 3'd1, 8'h05, 8'h0A, 4);

      run_instr("bz_fwd", enc_bz(3'd0, 3'd0, 6'd5), 0, -1, 1'b0, 3'd0, 8'h00, 8'h10, 4);
      run_instr("bz_back", enc_bz(3'd2, 3'd2, 6'b111110), 0, -1, 1'b0, 3'd0, 8'h00, 8'h0F, 4);
      run_instr("nop", enc(OP_ADD, 3'd0, 3'd0, 3'd0), 0, -1, 1'b0, 3'd0, 8'h00, 8'h10, 4);
      run_instr("bz_nt", enc_bz(3'd2, 3'd3, 6'b111110), 0, -1, 1'b0, 3'd0, 8'h00, 8'h11, 4);
      run_instr("bz_to_ff", enc_bz(3'd0, 3'd0, 6'b101101), 0, -1, 1'b0, 3'd0, 8'h00, 8'hFF, 4);
      run_instr("bz_wrap", enc_bz(3'd2, 3'd3, 6'b111110), 0, -1, 1'b0, 3'd0, 8'h00, 8'h00, 4);

      run_instr("ack_dly3", enc(OP_ADD, 3'd6, 3'd2, 3'd3), 3, -1, 1'b1, 3'd6, 8'h08, 8'h01, 7);

      // run low in FETCH: no request, pc held even with ack high
      imem_ack = 1'b1;
      run      = 1'b0;
      #1;
      check("run_low.imem_req", imem_req, 0);
      repeat (2) @(posedge clk);
      #1;
      check("run_low.pc", pc, 8'h01);
      check("run_low.imem_req_held", imem_req, 0);
      imem_ack = 1'b0;
      run      = 1'b1;
      #1;
      check("pending.imem_req", imem_req, 1);
      @(posedge clk);
      #1;
      run = 1'b0;
      #1;
      check("pending_drop.imem_req", imem_req, 0);
      @(posedge clk);
      #1;
      check("pending_drop.pc", pc, 8'h01);
      run = 1'b1;

      run_instr("illegal", enc(3'b101, 3'd1, 3'd2, 3'd3), 0, -1, 1'b0, 3'd0, 8'h00, 8'h02, 2);
      check("illegal.flag", illegal, 1);
      run_instr("after_ill", enc(OP_ADD, 3'd6, 3'd0, 3'd0), 0, -1, 1'b1, 3'd6, 8'h00, 8'h03, 4);
      check("illegal.sticky", illegal, 1);

      // reset while the ADD r1 sits in EXEC
      mem[pc_m] = enc(OP_ADD, 3'd1, 3'd2, 3'd3);
      imem_ack  = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("exec.alu_op", alu_op, OP_ADD);
      check("exec.alu_a", alu_a, 8'h05);
      check("exec.alu_b", alu_b, 8'h03);
      check("exec.wb_en", wb_en, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_exec.wb_en", wb_en, 0);
      check("rst_exec.pc", pc, 8'h00);
      check("rst_exec.illegal", illegal, 0);
      check("rst_exec.alu_a", alu_a, 8'h00);
      rst = 1'b0;
      #1;
      check("rst_exec.fetch", imem_req, 1);
      pc_m = 8'h00;
      run_instr("r1_cleared", enc(OP_OR, 3'd2, 3'd1, 3'd0), 0, -1, 1'b1, 3'd2, 8'h00, 8'h01, 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 The block SHALL have these ports (name direction width meaning), clock and reset first:
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 run  in  1  fetch enable; sampled only in FETCH.
REQ-005 imem_req  out  1  instruction fetch request.
REQ-006 imem_addr  out  8  fetch address, equal to pc.
REQ-007 imem_ack  in  1  fetch acknowledge; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  in  16  instruction word.
REQ-009 alu_op  out  3  opcode to the ALU (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 110, BZ 111).
REQ-010 alu_a, alu_b  out  8 each  ALU operands.
REQ-011 alu_ans  in  8  combinational ALU result.
REQ-012 alu_zero  in  1  ALU zero flag.
REQ-013 pc  out  8  program counter.
REQ-014 wb_en, wb_addr, wb_data  out  1/3/8  register write strobe, index and data, for observation.
REQ-015 illegal  out  1  sticky flag, set when opcode 101 is decoded.

Function
REQ-016 Instruction fields SHALL be: op [15:13], rd [11:9], rs [8:6], rt [5:3]; the BZ offset SHALL be the 6-bit signed value {[11:9],[2:0]}.
REQ-017 Internal register file SHALL be 8 x 8 bits; r0 reads 0 and writes to it are discarded.
REQ-018 FSM states SHALL be FETCH, DECODE, EXEC, WB; the machine SHALL never leave this set.
REQ-019 FETCH: imem_req = run. When imem_req and imem_ack are both high, the instruction register SHALL latch imem_rdata and the state SHALL go to DECODE. Otherwise the state SHALL stay FETCH.
REQ-020 If run falls while a request is pending, imem_req SHALL drop. No instruction is latched without ack.
REQ-021 DECODE: operand registers SHALL latch reg[rs] and reg[rt], and alu_op SHALL latch op. Opcode 101 SHALL set illegal, advance pc by 1 and go to FETCH with no write.
REQ-022 EXEC: alu_op, alu_a and alu_b SHALL be stable for the whole cycle. alu_ans and alu_zero SHALL be captured at its end. Next state is WB.
REQ-023 WB, non-BZ op: if rd != 0, assert wb_en for exactly one cycle with wb_addr = rd and wb_data = captured ans, and write reg[rd]. pc <= pc+1.
REQ-024 WB, BZ op: no register write. pc <= pc+1+offset if the captured zero flag = 1, else pc+1.
REQ-025 All pc arithmetic SHALL be mod 256 (0xFF+1 = 0x00; negative offsets wrap).
REQ-026 Latency SHALL be 4 cycles per instruction when ack arrives in the first FETCH cycle; each cycle of ack delay adds one cycle.
REQ-027 A register written in WB SHALL be visible to the next instruction's DECODE (no hazard, since the machine is non-pipelined).
REQ-028 wb_en SHALL be 0 in every state except WB.

Reset
REQ-029 While rst is high at a clock edge, the block SHALL set: state FETCH, pc 0x00, all registers 0x00, imem_req 0, alu_op 000, alu_a/alu_b 0x00, wb_en 0, wb_addr 0, wb_data 0x00, illegal 0.
REQ-030 Reset SHALL override any state mid-instruction, including a pending WB write, which SHALL NOT occur.
REQ-031 imem_req SHALL first rise on the cycle after rst deasserts, if run = 1.

Structure
REQ-032 A shared package gcore_pkg SHALL hold the opcode constants, the FSM state encoding, and the instruction field bit positions. The ALU SHALL use the same opcode constants.
REQ-033 The register file SHALL be a sub-module regfile: 2 combinational read ports, 1 synchronous write port, r0 fixed at zero.
REQ-034 exec_ctrl SHALL NOT instantiate the ALU; it connects to the ALU through ports.

Verification
REQ-035 Reset, run=1, ack tied high, instruction ADD r1,r0,r0 at address 0 -> wb_en pulses at cycle 4 with wb_addr 1, wb_data 0x00; pc = 0x01.
REQ-036 Preload r2=0x05, r3=0x03 via prior ADDs, then SUB r4,r2,r3 -> wb_data 0x02. SLT r5,r3,r2 -> wb_data 0x01. SLT r5,r2,r3 -> wb_data 0x00.
REQ-037 BZ at pc 0x10 with rs = rt, offset -2 -> pc 0x0F. Same instruction with rs != rt -> pc 0x11. BZ at pc 0xFF with zero = 0 -> pc 0x00.
REQ-038 ack delayed 3 cycles -> imem_req held high and imem_addr stable throughout; the instruction completes in 7 cycles. run dropped during FETCH -> imem_req low and pc unchanged.
REQ-039 Opcode 101 -> illegal = 1 and stays 1; no wb_en; pc+1. Next an ADD r6,r0,r0 executes normally.
REQ-040 rst asserted in EXEC of ADD r1,... -> no wb_en. Next cycle: state FETCH, pc 0x00, r1 reads 0x00.
